// File: rtl/xaui_link_sequencer.sv
// XAUI transceiver bank bring-up/recovery sequencer: reset, lock, comma align,
// channel bonding, link-up monitoring and back-off retry, all in the mgt_clk domain.
module xaui_link_sequencer #(
  parameter int unsigned RESET_CYCLES   = 64,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned ALIGN_CYCLES   = 1024,
  parameter int unsigned SYNC_TIMEOUT   = 4096,
  parameter int unsigned BACKOFF_CYCLES = 8192,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       i_mgt_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [3:0] i_rxlock,
  input  logic [3:0] i_syncok,
  input  logic [7:0] i_codevalid,
  input  logic [3:0] i_rxbufferr,
  output logic       o_mgt_reset,
  output logic       o_mgt_tx_reset,
  output logic       o_mgt_rx_reset,
  output logic [3:0] o_enable_align,
  output logic       o_enchansync,
  output logic       o_link_up,
  output logic [7:0] o_retry_count,
  output logic [2:0] o_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RESET     = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_ALIGN     = 3'd3;
  localparam logic [2:0] S_CHANSYNC  = 3'd4;
  localparam logic [2:0] S_UP        = 3'd5;
  localparam logic [2:0] S_FAIL      = 3'd6;

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ALIGN_LAST   = CNT_W'(ALIGN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST    = CNT_W'(SYNC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYCLES - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_retry;
  logic             r_mgt_reset, r_mgt_tx_reset, r_mgt_rx_reset;
  logic [3:0]       r_enable_align;
  logic             r_enchansync, r_link_up;

  logic [2:0] w_next;
  logic       w_all_lock, w_all_sync, w_all_code;
  logic       w_mgt_reset, w_mgt_tx_reset, w_mgt_rx_reset;
  logic [3:0] w_enable_align;
  logic       w_enchansync, w_link_up;

  assign w_all_lock = (i_rxlock == 4'hF);
  assign w_all_sync = (i_syncok == 4'hF);
  assign w_all_code = (i_codevalid == 8'hFF);

  // Next-state logic plus output decode of the next state, so the output
  // registers always match a decode of r_state.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (i_enable) w_next = S_RESET;
      S_RESET:     if (r_cnt == RESET_LAST) w_next = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (w_all_lock)              w_next = S_ALIGN;
        else if (r_cnt == LOCK_LAST) w_next = S_FAIL;
      end
      S_ALIGN: begin
        if (!w_all_lock)              w_next = S_FAIL;
        else if (r_cnt == ALIGN_LAST) w_next = w_all_code ? S_CHANSYNC : S_FAIL;
      end
      S_CHANSYNC: begin
        if (w_all_sync)              w_next = S_UP;
        else if (r_cnt == SYNC_LAST) w_next = S_FAIL;
      end
      S_UP: begin
        if ((i_rxbufferr != 4'h0) || !w_all_lock || !w_all_sync || !w_all_code)
          w_next = S_FAIL;
      end
      S_FAIL:  if (r_cnt == BACKOFF_LAST) w_next = S_RESET;
      default: w_next = S_IDLE;
    endcase
    if (!i_enable) w_next = S_IDLE;

    w_mgt_reset    = 1'b1;
    w_mgt_tx_reset = 1'b1;
    w_mgt_rx_reset = 1'b1;
    w_enable_align = 4'h0;
    w_enchansync   = 1'b0;
    w_link_up      = 1'b0;
    unique case (w_next)
      S_WAIT_LOCK: begin
        w_mgt_reset    = 1'b0;
        w_mgt_tx_reset = 1'b0;
      end
      S_ALIGN: begin
        w_mgt_reset    = 1'b0;
        w_mgt_tx_reset = 1'b0;
        w_mgt_rx_reset = 1'b0;
        w_enable_align = 4'hF;
      end
      S_CHANSYNC: begin
        w_mgt_reset    = 1'b0;
        w_mgt_tx_reset = 1'b0;
        w_mgt_rx_reset = 1'b0;
        w_enchansync   = 1'b1;
      end
      S_UP: begin
        w_mgt_reset    = 1'b0;
        w_mgt_tx_reset = 1'b0;
        w_mgt_rx_reset = 1'b0;
        w_link_up      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_mgt_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_retry        <= 8'd0;
      r_mgt_reset    <= 1'b1;
      r_mgt_tx_reset <= 1'b1;
      r_mgt_rx_reset <= 1'b1;
      r_enable_align <= 4'h0;
      r_enchansync   <= 1'b0;
      r_link_up      <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cnt          <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
      r_mgt_reset    <= w_mgt_reset;
      r_mgt_tx_reset <= w_mgt_tx_reset;
      r_mgt_rx_reset <= w_mgt_rx_reset;
      r_enable_align <= w_enable_align;
      r_enchansync   <= w_enchansync;
      r_link_up      <= w_link_up;
      // Count each entry into FAIL, saturating.
      if ((w_next == S_FAIL) && (r_state != S_FAIL) && (r_retry != 8'hFF))
        r_retry <= r_retry + 8'd1;
    end
  end

  assign o_state        = r_state;
  assign o_retry_count  = r_retry;
  assign o_mgt_reset    = r_mgt_reset;
  assign o_mgt_tx_reset = r_mgt_tx_reset;
  assign o_mgt_rx_reset = r_mgt_rx_reset;
  assign o_enable_align = r_enable_align;
  assign o_enchansync   = r_enchansync;
  assign o_link_up      = r_link_up;

endmodule
